// File: rtl/key_encoder.sv
// Eight-line debounced key encoder: synchronizes and debounces active-low key
// lines, queues press events per line and reports them lowest-index-first.
module key_encoder #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_n,
  input  logic       ready,
  input  logic       clear_ovf,
  output logic [2:0] code,
  output logic       valid,
  output logic [7:0] pressed,
  output logic       overflow
);

  localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

  logic [7:0]      sync1_q, sync2_q;
  logic [7:0][7:0] cnt_q, cnt_d;
  logic [7:0]      pressed_q, pressed_d;
  logic [7:0]      pend_q, pend_d;
  logic [2:0]      code_q, code_d;
  logic            valid_q, valid_d;
  logic            ovf_q, ovf_d;

  logic [7:0]      press_evt;
  logic [7:0]      take_mask;
  logic [2:0]      pick_idx;
  logic            out_free;

  // Debounce: a line must disagree with its debounced level for
  // DEBOUNCE_CYCLES consecutive edges before the level follows it.
  always_comb begin
    cnt_d     = cnt_q;
    pressed_d = pressed_q;
    for (int i = 0; i < 8; i++) begin
      if (sync2_q[i] == pressed_q[i]) begin
        cnt_d[i] = 8'd0;
      end else if (cnt_q[i] == CNT_MAX) begin
        cnt_d[i]     = 8'd0;
        pressed_d[i] = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  // Handshake: code/valid form a valid/ready source; a transfer occurs on any
  // edge with valid=1 and ready=1, and code/valid hold while valid=1, ready=0.
  always_comb begin
    press_evt = pressed_d & ~pressed_q;
    out_free  = ~valid_q | ready;

    pick_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pend_q[i]) pick_idx = 3'(i);
    end

    take_mask = 8'd0;
    code_d    = code_q;
    valid_d   = valid_q;
    if (out_free) begin
      if (pend_q != 8'd0) begin
        take_mask = 8'd1 << pick_idx;
        code_d    = pick_idx;
        valid_d   = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end

    // A press landing on a still-pending line is merged and flagged; one that
    // lands as its bit is being consumed simply re-arms the bit.
    pend_d = (pend_q & ~take_mask) | press_evt;
    if ((press_evt & pend_q & ~take_mask) != 8'd0) begin
      ovf_d = 1'b1;
    end else if (clear_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= 8'd0;
      sync2_q   <= 8'd0;
      cnt_q     <= '0;
      pressed_q <= 8'd0;
      pend_q    <= 8'd0;
      code_q    <= 3'd0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      sync1_q   <= ~in_n;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
      pend_q    <= pend_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign code     = code_q;
  assign valid    = valid_q;
  assign pressed  = pressed_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_key_encoder.sv
// Self-checking bench for key_encoder: scenario tasks plus a scoreboard that
// checks every delivered code against the expected press order.
module tb_key_encoder;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_n = 8'hFF;
  logic       ready = 1'b0;
  logic       clear_ovf = 1'b0;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pressed;
  logic       overflow;

  int vectors = 0;
  int errors  = 0;
  logic [2:0] exp_q[$];
  logic [2:0] mon_exp;

  key_encoder #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_n     (in_n),
    .ready    (ready),
    .clear_ovf(clear_ovf),
    .code     (code),
    .valid    (valid),
    .pressed  (pressed),
    .overflow (overflow)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  // Scoreboard: inputs only change just after posedge, so the values seen at
  // negedge are the ones the next posedge will transfer on.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid === 1'b1 && ready === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got code=%0d, expected no transfer", code);
      end else begin
        mon_exp = exp_q.pop_front();
        if (code !== mon_exp) begin
          errors++;
          $display("FAIL sb_code: got code=%0d, expected %0d", code, mon_exp);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    in_n  = 8'h00;
    for (int i = 0; i < 4; i++) begin
      ready     = 1'($urandom_range(0, 1));
      clear_ovf = 1'($urandom_range(0, 1));
      tick();
      vectors++;
      if ({code, valid, pressed, overflow} !== 13'd0) begin
        errors++;
        $display("FAIL reset_outputs: got code=%0d valid=%b pressed=%h ovf=%b, expected all 0",
                 code, valid, pressed, overflow);
      end
    end
    in_n = 8'hFF; ready = 1'b0; clear_ovf = 1'b0;
    tick();
    rst_n = 1'b1;
    settle(10);
    vectors++;
    if (pressed !== 8'h00 || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got pressed=%h valid=%b, expected 00/0", pressed, valid);
    end
  endtask

  task automatic test_latency();
    ready = 1'b1;
    exp_q.push_back(3'd5);
    in_n = 8'hDF;
    for (int e = 1; e <= 8; e++) begin
      tick();
      vectors++;
      if (valid !== (e == 7) || pressed !== ((e >= 6) ? 8'h20 : 8'h00)) begin
        errors++;
        $display("FAIL latency_edge%0d: got valid=%b pressed=%h, expected %b/%h",
                 e, valid, pressed, (e == 7), ((e >= 6) ? 8'h20 : 8'h00));
      end
      if (e == 7) begin
        vectors++;
        if (code !== 3'd5) begin
          errors++;
          $display("FAIL latency_code: got %0d, expected 5", code);
        end
      end
    end
    in_n = 8'hFF;
    settle(10);
    vectors++;
    if (pressed !== 8'h00 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL latency_release: got pressed=%h pending_exp=%0d, expected 00/0",
               pressed, exp_q.size());
    end
  endtask

  task automatic test_glitch();
    ready = 1'b1;
    in_n  = 8'hFB;
    settle(DC - 1);
    in_n = 8'hFF;
    for (int i = 0; i < 12; i++) begin
      tick();
      vectors++;
      if (pressed !== 8'h00 || valid !== 1'b0) begin
        errors++;
        $display("FAIL glitch_cycle%0d: got pressed=%h valid=%b, expected 00/0",
                 i, pressed, valid);
      end
    end
  endtask

  task automatic test_priority();
    bit got;
    ready = 1'b0;
    in_n  = 8'b0110_1011;
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd4);
    exp_q.push_back(3'd7);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = (valid === 1'b1);
    end
    vectors++;
    if (!got || code !== 3'd2) begin
      errors++;
      $display("FAIL prio_first: got valid=%b code=%0d, expected 1/2", valid, code);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (valid !== 1'b1 || code !== 3'd2) begin
        errors++;
        $display("FAIL prio_hold: got valid=%b code=%0d, expected 1/2", valid, code);
      end
    end
    ready = 1'b1;
    tick();
    vectors++;
    if (valid !== 1'b1 || code !== 3'd4) begin
      errors++;
      $display("FAIL prio_second: got valid=%b code=%0d, expected 1/4", valid, code);
    end
    tick();
    vectors++;
    if (valid !== 1'b1 || code !== 3'd7) begin
      errors++;
      $display("FAIL prio_third: got valid=%b code=%0d, expected 1/7", valid, code);
    end
    tick();
    vectors++;
    if (valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL prio_drain: got valid=%b pending_exp=%0d, expected 0/0",
               valid, exp_q.size());
    end
    in_n = 8'hFF;
    settle(10);
  endtask

  task automatic test_overflow();
    bit got;
    ready = 1'b0;
    in_n  = 8'hFE;
    exp_q.push_back(3'd0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = (valid === 1'b1);
    end
    vectors++;
    if (!got || code !== 3'd0) begin
      errors++;
      $display("FAIL ovf_hold_reg: got valid=%b code=%0d, expected 1/0", valid, code);
    end
    in_n = 8'hFC;
    settle(8);
    vectors++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_first_press: got overflow=%b, expected 0", overflow);
    end
    in_n = 8'hFE;
    settle(8);
    in_n = 8'hFC;
    settle(8);
    vectors++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_merge: got overflow=%b, expected 1", overflow);
    end
    exp_q.push_back(3'd1);
    ready = 1'b1;
    settle(5);
    vectors++;
    if (exp_q.size() != 0 || valid !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_deliver: got pending_exp=%0d valid=%b ovf=%b, expected 0/0/1",
               exp_q.size(), valid, overflow);
    end
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    vectors++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got overflow=%b, expected 0", overflow);
    end
    in_n = 8'hFF;
    settle(10);
  endtask

  task automatic test_reset_mid();
    bit got;
    ready = 1'b0;
    in_n  = 8'hF7;
    exp_q.push_back(3'd3);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = (valid === 1'b1);
    end
    vectors++;
    if (!got || code !== 3'd3) begin
      errors++;
      $display("FAIL rstmid_pre: got valid=%b code=%0d, expected 1/3", valid, code);
    end
    rst_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({code, valid, pressed, overflow} !== 13'd0) begin
        errors++;
        $display("FAIL rstmid_outputs: got code=%0d valid=%b pressed=%h ovf=%b, expected all 0",
                 code, valid, pressed, overflow);
      end
    end
    rst_n = 1'b1;
    exp_q.push_back(3'd3);
    for (int e = 1; e <= 7; e++) begin
      tick();
      vectors++;
      if (valid !== (e == 7)) begin
        errors++;
        $display("FAIL rstmid_edge%0d: got valid=%b, expected %b", e, valid, (e == 7));
      end
    end
    vectors++;
    if (code !== 3'd3) begin
      errors++;
      $display("FAIL rstmid_code: got %0d, expected 3", code);
    end
    ready = 1'b1;
    settle(3);
    vectors++;
    if (exp_q.size() != 0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_replay: got pending_exp=%0d valid=%b, expected 0/0",
               exp_q.size(), valid);
    end
    in_n = 8'hFF;
    settle(10);
  endtask

  // Lines pressed in ascending order and held, with random ready stalls:
  // delivery order must equal press order with no loss and no overflow.
  task automatic test_back_to_back();
    logic [7:0] pat;
    for (int round = 0; round < 4; round++) begin
      pat   = 8'h00;
      ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          pat[i] = 1'b1;
          in_n   = ~pat;
          exp_q.push_back(3'(i));
        end
        repeat ($urandom_range(1, 12)) begin
          ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
      ready = 1'b1;
      settle(25);
      vectors++;
      if (exp_q.size() != 0 || pressed !== pat || overflow !== 1'b0 || valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_round%0d: got pending_exp=%0d pressed=%h ovf=%b valid=%b, expected 0/%h/0/0",
                 round, exp_q.size(), pressed, overflow, valid, pat);
      end
      in_n = 8'hFF;
      settle(10);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_priority();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
